// File: rtl/result_packet_tx_pkg.sv
// Shared definitions for the result framer.
//  - SYNC_BYTE_DEFAULT : frame header byte
//  - tx_state_e        : serializer FSM states
//  - clog2()           : constant ceil(log2) used for pointer/counter widths
package result_packet_tx_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSend,
      StWaitBusy,
      StWaitIdle
   } tx_state_e;

   // ceil(log2(value)); returns 0 for value <= 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) begin
         res++;
      end
      return res;
   endfunction

endpackage

// File: rtl/result_packet_tx_if.sv
// Bundle of the framer's result-input and UART-side signals.
//  in_valid/in_ready/in_data : result word handshake (producer -> framer)
//  tx_start/tx_data/tx_busy  : byte handshake (framer -> UART transmitter)
//  fifo_count/frame_active   : status outputs
// Modports: slave = framer side, master = environment (result source + transmitter).
interface result_packet_tx_if
   import result_packet_tx_pkg::*;
#(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned FIFO_DEPTH = 4
);
   logic                          in_valid;
   logic                          in_ready;
   logic [8*WORD_BYTES-1:0]       in_data;
   logic                          tx_start;
   logic [7:0]                    tx_data;
   logic                          tx_busy;
   logic [clog2(FIFO_DEPTH):0]    fifo_count;
   logic                          frame_active;

   modport slave (
      input  in_valid, in_data, tx_busy,
      output in_ready, tx_start, tx_data, fifo_count, frame_active
   );

   modport master (
      output in_valid, in_data, tx_busy,
      input  in_ready, tx_start, tx_data, fifo_count, frame_active
   );
endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO holding result words ahead of the serializer.
//  clk, rst  : clock, synchronous active-high reset (flushes pointers/count)
//  push_i    : write wdata_i (accepted when not full, or when full and popping)
//  pop_i     : advance read pointer (ignored when empty)
//  rdata_o   : head word (valid when !empty_o)
//  count_o   : words held; full_o / empty_o status
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module result_fifo
   import result_packet_tx_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [clog2(DEPTH):0]    count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int unsigned PtrW = clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   assign pop_ok  = pop_i && !empty_o;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) wptr_d = wptr_q + PtrW'(1);
      if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/result_packet_tx.sv
// Result framer: buffers result words and sends each as
//   SYNC_BYTE, payload bytes MSB-first, XOR checksum of the payload
// over a UART transmitter start/busy handshake.
//  clk, rst : clock, synchronous active-high reset (aborts any frame in flight)
//  bus      : result_packet_tx_if.slave
//    in_valid/in_ready/in_data  result word input, in_ready = FIFO not full
//    tx_start/tx_data/tx_busy   one-cycle start pulse + byte, transmitter busy
//    fifo_count                 words waiting (excludes the word being sent)
//    frame_active               high from frame load until the last byte completes
module result_packet_tx
   import result_packet_tx_pkg::*;
#(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   result_packet_tx_if.slave   bus
);
   localparam int unsigned W    = 8 * WORD_BYTES;
   localparam int unsigned IdxW = clog2(WORD_BYTES + 2);

   // byte_idx: 0 = sync, 1..WORD_BYTES = payload, WORD_BYTES+1 = checksum
   localparam logic [IdxW-1:0] IdxLastPay = IdxW'(WORD_BYTES);
   localparam logic [IdxW-1:0] IdxCsum    = IdxW'(WORD_BYTES + 1);

   tx_state_e       state_q, state_d;
   logic [W-1:0]    shift_q, shift_d;
   logic [7:0]      csum_q, csum_d;
   logic [7:0]      byte_q, byte_d;
   logic [IdxW-1:0] idx_q, idx_d;

   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [W-1:0]    fifo_rdata;
   logic            tx_start;
   logic [7:0]      top_byte;

   assign top_byte = shift_q[W-1 -: 8];

   assign fifo_push = bus.in_valid && !fifo_full;

   result_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i (bus.in_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (bus.fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.in_ready     = !fifo_full;
   assign bus.tx_start     = tx_start;
   assign bus.tx_data      = byte_q;
   assign bus.frame_active = (state_q != StIdle);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      csum_d   = csum_q;
      byte_d   = byte_q;
      idx_d    = idx_q;
      fifo_pop = 1'b0;
      tx_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               csum_d   = '0;
               idx_d    = '0;
               state_d  = StLoad;
            end
         end
         StLoad: begin
            byte_d  = SYNC_BYTE;
            state_d = StSend;
         end
         StSend: begin
            // Gating on tx_busy keeps a start pulse from ever landing on a busy transmitter.
            if (!bus.tx_busy) begin
               tx_start = 1'b1;
               state_d  = StWaitBusy;
            end
         end
         StWaitBusy: begin
            if (bus.tx_busy) state_d = StWaitIdle;
         end
         StWaitIdle: begin
            if (!bus.tx_busy) begin
               if (idx_q == IdxCsum) begin
                  state_d = StIdle;
               end else begin
                  state_d = StSend;
                  idx_d   = idx_q + IdxW'(1);
                  if (idx_q == IdxLastPay) begin
                     byte_d = csum_q;
                  end else begin
                     // Payload byte: fold into checksum as it is staged.
                     byte_d  = top_byte;
                     csum_d  = csum_q ^ top_byte;
                     shift_d = shift_q << 8;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         csum_q  <= '0;
         byte_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         csum_q  <= csum_d;
         byte_q  <= byte_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_result_packet_tx.sv
// Directed bench for result_packet_tx with a byte scoreboard and a
// transmitter model whose busy rises the cycle after start and holds BusyN cycles.
module tb_result_packet_tx;

   localparam int BusyN = 10;

   logic clk;
   logic rst;

   result_packet_tx_if #(.WORD_BYTES(4), .FIFO_DEPTH(4)) bus ();

   result_packet_tx #(
      .WORD_BYTES (4),
      .FIFO_DEPTH (4),
      .SYNC_BYTE  (8'hAA)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmitter model; busy_force holds busy high (registered, like the real busy).
   int   busy_cnt;
   logic busy_force;
   logic force_q;
   always @(posedge clk) begin
      force_q <= busy_force;
      if (bus.tx_start)     busy_cnt <= BusyN;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign bus.tx_busy = force_q | (busy_cnt != 0);

   int         n_cmp;
   int         n_err;
   int         n_pulses;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every start pulse must carry the next expected byte.
   always @(negedge clk) begin
      if (!rst && bus.tx_start) begin
         n_pulses++;
         check("start_while_busy", 64'(bus.tx_busy), 64'd0);
         if (exp_q.size() == 0) check("unexpected_tx_start", 64'd1, 64'd0);
         else check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
      end
   end

   task automatic add_frame(input logic [31:0] w);
      logic [7:0] cs;
      logic [7:0] b;
      cs = 8'h00;
      exp_q.push_back(8'hAA);
      for (int k = 3; k >= 0; k--) begin
         b  = w[8*k +: 8];
         cs = cs ^ b;
         exp_q.push_back(b);
      end
      exp_q.push_back(cs);
   endtask

   // Offer a word from a negedge; returns at the negedge after the transfer.
   task automatic try_push(input logic [31:0] w, input int budget, input bit use_model,
                           output bit ok);
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      for (int i = 0; i < budget && !ok; i++) begin
         if (bus.in_ready) ok = 1'b1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      if (ok && use_model) add_frame(w);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (exp_q.size() == 0 && !bus.frame_active && bus.fifo_count == 0) done = 1'b1;
         else @(negedge clk);
      end
      check(tag, 64'(done), 64'd1);
   endtask

   initial begin
      bit          ok;
      int          p0;
      logic [31:0] w;
      n_cmp = 0; n_err = 0; n_pulses = 0;
      busy_cnt = 0; busy_force = 1'b0; force_q = 1'b0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
      check("rst_tx_start", 64'(bus.tx_start), 64'd0);
      check("rst_tx_data", 64'(bus.tx_data), 64'd0);
      check("rst_frame_active", 64'(bus.frame_active), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: single frame, latency and byte content
      p0 = n_pulses;
      exp_q.push_back(8'hAA); exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
      exp_q.push_back(8'hBE); exp_q.push_back(8'hEF); exp_q.push_back(8'h22);
      try_push(32'hDEADBEEF, 4, 1'b0, ok);
      check("t1_accept", 64'(ok), 64'd1);
      @(negedge clk);
      check("t1_no_start_c2", 64'(bus.tx_start), 64'd0);
      check("t1_active_load", 64'(bus.frame_active), 64'd1);
      @(negedge clk);
      check("t1_start_c3", 64'(bus.tx_start), 64'd1);
      for (int i = 0; i < 200 && n_pulses < p0 + 6; i++) @(negedge clk);
      check("t1_active_last", 64'(bus.frame_active), 64'd1);
      wait_drain("t1_drain", 100);
      check("t1_pulses", 64'(n_pulses - p0), 64'd6);

      // 2: busy held, fill FIFO, sixth word refused, then release
      busy_force = 1'b1;
      p0 = n_pulses;
      for (int i = 0; i < 5; i++) begin
         try_push($urandom, 5, 1'b1, ok);
         check("t2_fill_accept", 64'(ok), 64'd1);
      end
      try_push(32'h12345678, 5, 1'b0, ok);
      check("t2_full_reject", 64'(ok), 64'd0);
      check("t2_fifo_count", 64'(bus.fifo_count), 64'd4);
      check("t2_in_ready", 64'(bus.in_ready), 64'd0);
      repeat (5) @(negedge clk);
      check("t2_no_start", 64'(n_pulses - p0), 64'd0);
      busy_force = 1'b0;
      wait_drain("t2_drain", 1500);
      check("t2_pulses", 64'(n_pulses - p0), 64'd30);

      // 3: full FIFO, new word taken as soon as a pop frees a slot
      busy_force = 1'b1;
      p0 = n_pulses;
      for (int i = 0; i < 5; i++) try_push($urandom, 5, 1'b1, ok);
      check("t3_full_count", 64'(bus.fifo_count), 64'd4);
      busy_force = 1'b0;
      w = $urandom;
      try_push(w, 300, 1'b1, ok);
      check("t3_late_accept", 64'(ok), 64'd1);
      check("t3_count_after", 64'(bus.fifo_count), 64'd4);
      wait_drain("t3_drain", 1800);
      check("t3_pulses", 64'(n_pulses - p0), 64'd36);

      // 4: reset during the third byte of a frame
      p0 = n_pulses;
      try_push(32'hCAFEF00D, 4, 1'b1, ok);
      try_push(32'h0BADC0DE, 4, 1'b1, ok);
      for (int i = 0; i < 200 && n_pulses < p0 + 3; i++) @(negedge clk);
      check("t4_reach_byte3", 64'(n_pulses >= p0 + 3), 64'd1);
      check("t4_pre_count", 64'(bus.fifo_count), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t4_rst_tx_start", 64'(bus.tx_start), 64'd0);
      check("t4_rst_fifo_count", 64'(bus.fifo_count), 64'd0);
      check("t4_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("t4_rst_frame_active", 64'(bus.frame_active), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      p0 = n_pulses;
      try_push(32'h13579BDF, 4, 1'b1, ok);
      wait_drain("t4_drain", 300);
      check("t4_pulses", 64'(n_pulses - p0), 64'd6);

      // 5: payload bytes equal to sync are sent unescaped
      p0 = n_pulses;
      exp_q.push_back(8'hAA);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h00);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'hAA);
      exp_q.push_back(8'h00);
      try_push(32'h00000000, 4, 1'b0, ok);
      try_push(32'hAAAAAAAA, 4, 1'b0, ok);
      wait_drain("t5_drain", 400);
      check("t5_pulses", 64'(n_pulses - p0), 64'd12);

      // 6: busy high when SEND is entered
      busy_force = 1'b1;
      p0 = n_pulses;
      try_push(32'h89ABCDEF, 4, 1'b1, ok);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t6_withheld", 64'(bus.tx_start), 64'd0);
      end
      check("t6_active", 64'(bus.frame_active), 64'd1);
      busy_force = 1'b0;
      @(negedge clk);
      check("t6_start_after_release", 64'(bus.tx_start), 64'd1);
      wait_drain("t6_drain", 300);
      check("t6_pulses", 64'(n_pulses - p0), 64'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
